// File: rtl/spi_slave_regfile.sv
// ============================================================================
// spi_slave_regfile : SPI mode-0 slave exposing NREG 16-bit registers through
// 3-byte frames {rw,addr[6:0]}, DATA_HI, DATA_LO. Optional write IRQ under
// the SPI_SLAVE_WR_IRQ_EN macro. Revision: 1.0
// ============================================================================
`default_nettype none

module spi_slave_regfile #(
    parameter int          NREG    = 4,
    parameter logic [15:0] RST_VAL = 16'h0000,
    parameter logic [7:0]  SIG     = 8'hA5
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic                 spi_SCLK,
    input  logic                 spi_MOSI,
    input  logic                 spi_SS_n,
    output logic                 spi_MISO,
    output logic                 spi_MISO_oe,
    output logic [NREG*16-1:0]   reg_q,
    output logic                 wr_strobe,
    output logic [6:0]           wr_addr
`ifdef SPI_SLAVE_WR_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam int         AW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0] NREG8 = 8'(NREG);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t      state_q;
    logic [2:0]  sclk_q;
    logic [2:0]  ss_q;
    logic [1:0]  mosi_q;
    logic [4:0]  bit_cnt_q;
    logic [15:0] rx_q;
    logic [15:0] tx_q;
    logic [7:0]  cmd_q;
    logic        miso_q;
    logic        oe_q;
    logic        wr_pend_q;
    logic [15:0] regs_q [NREG];

    logic        sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [15:0] rx_d;
    logic [15:0] rd_data_d;
    logic        cmd_in_range;

    assign sclk_rise    = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall    = ~sclk_q[1] & sclk_q[2];
    assign ss_fall      = ~ss_q[1] & ss_q[2];
    assign ss_rise      = ss_q[1] & ~ss_q[2];
    assign rx_d         = {rx_q[14:0], mosi_q[1]};
    assign cmd_in_range = {1'b0, cmd_q[6:0]} < NREG8;

    // Read word is snapshotted from the command byte completing on this rise.
    always_comb begin
        rd_data_d = 16'h0000;
        if (rx_d[7] && ({1'b0, rx_d[6:0]} < NREG8)) begin
            rd_data_d = regs_q[rx_d[AW-1:0]];
        end
`ifdef SPI_SLAVE_WR_IRQ_EN
        if (rx_d[7:0] == 8'hFF) begin
            rd_data_d = {9'd0, wr_addr};
        end
`endif
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= S_IDLE;
            sclk_q    <= 3'b000;
            ss_q      <= 3'b111;
            mosi_q    <= 2'b00;
            bit_cnt_q <= 5'd0;
            rx_q      <= 16'h0000;
            tx_q      <= 16'h0000;
            cmd_q     <= 8'h00;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 7'd0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RST_VAL;
            end
`ifdef SPI_SLAVE_WR_IRQ_EN
            irq       <= 1'b0;
`endif
        end else begin
            sclk_q    <= {sclk_q[1:0], spi_SCLK};
            ss_q      <= {ss_q[1:0], spi_SS_n};
            mosi_q    <= {mosi_q[0], spi_MOSI};
            oe_q      <= ~ss_q[1];
            wr_strobe <= 1'b0;

            if (wr_pend_q) begin
                regs_q[cmd_q[AW-1:0]] <= rx_q;
                wr_strobe             <= 1'b1;
                wr_addr               <= cmd_q[6:0];
                wr_pend_q             <= 1'b0;
`ifdef SPI_SLAVE_WR_IRQ_EN
                irq                   <= 1'b1;
`endif
            end

            if (ss_rise) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= 5'd0;
                rx_q      <= 16'h0000;
                tx_q      <= 16'h0000;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (ss_fall) begin
                            state_q   <= S_CMD;
                            bit_cnt_q <= 5'd0;
                            tx_q      <= {SIG[6:0], 9'd0};
                            miso_q    <= SIG[7];
                        end
                    end
                    S_CMD, S_DATA: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_d;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd7) begin
                                state_q <= S_DATA;
                                cmd_q   <= rx_d[7:0];
                                tx_q    <= rd_data_d;
`ifdef SPI_SLAVE_WR_IRQ_EN
                                if (rx_d[7:0] == 8'hFF) begin
                                    irq <= 1'b0;
                                end
`endif
                            end else if (bit_cnt_q == 5'd23) begin
                                state_q   <= S_DONE;
                                miso_q    <= 1'b0;
                                wr_pend_q <= ~cmd_q[7] & cmd_in_range;
                            end
                        end else if (sclk_fall) begin
                            miso_q <= tx_q[15];
                            tx_q   <= {tx_q[14:0], 1'b0};
                        end
                    end
                    default: begin
                        miso_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_MISO    = oe_q & miso_q;
    assign spi_MISO_oe = oe_q;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_out
        assign reg_q[16*gi +: 16] = regs_q[gi];
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: table of SPI frames with a MISO
// scoreboard, plus hand sequences for mid-frame reset and the optional IRQ.
`default_nettype none

module tb_spi_slave_regfile;

    localparam int NREG = 4;
    localparam int HALF = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              mosi = 1'b0;
    logic              ss_n = 1'b1;
    logic              miso;
    logic              oe;
    logic [NREG*16-1:0] regq;
    logic              strobe;
    logic [6:0]        waddr;
`ifdef SPI_SLAVE_WR_IRQ_EN
    logic              irq;
`endif

    spi_slave_regfile #(
        .NREG    (NREG),
        .RST_VAL (16'h0000),
        .SIG     (8'hA5)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .spi_SCLK    (sclk),
        .spi_MOSI    (mosi),
        .spi_SS_n    (ss_n),
        .spi_MISO    (miso),
        .spi_MISO_oe (oe),
        .reg_q       (regq),
        .wr_strobe   (strobe),
        .wr_addr     (waddr)
`ifdef SPI_SLAVE_WR_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int strobe_cnt = 0;
    logic [23:0] exp_q[$];

    always @(posedge clk) begin
        if (strobe) strobe_cnt <= strobe_cnt + 1;
    end

    typedef struct {
        logic [23:0] frame;
        int          nbits;
        logic        chk_miso;
        logic [23:0] exp_miso;
        int          exp_strobes;
        logic [6:0]  exp_waddr;
        logic [63:0] exp_regs;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input logic [23:0] frame, input int nbits, input logic chk_miso,
                             input logic [23:0] exp_miso, input string name);
        logic [23:0] cap;
        logic [23:0] want;
        cap = 24'h0;
        if (chk_miso) exp_q.push_back(exp_miso);
        ss_n = 1'b0;
        clks(8);
        check({name, " oe_active"}, 64'(oe), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 24) ? frame[23-i] : 1'b1;
            clks(HALF);
            if (i < 24) cap[23-i] = miso;
            sclk = 1'b1;
            clks(HALF);
            sclk = 1'b0;
        end
        clks(HALF);
        ss_n = 1'b1;
        clks(8);
        if (chk_miso) begin
            want = exp_q.pop_front();
            check({name, " miso"}, 64'(cap), 64'(want));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        //            frame        nb  chk   miso        stb wa     {r3,r2,r1,r0}
        vecs[0]  = '{24'h021234, 24, 1'b1, 24'hA50000, 1, 7'd2, 64'h0000_1234_0000_0000};
        vecs[1]  = '{24'h820000, 24, 1'b1, 24'hA51234, 0, 7'd2, 64'h0000_1234_0000_0000};
        vecs[2]  = '{24'h05FFFF, 24, 1'b1, 24'hA50000, 0, 7'd2, 64'h0000_1234_0000_0000};
        vecs[3]  = '{24'h850000, 24, 1'b1, 24'hA50000, 0, 7'd2, 64'h0000_1234_0000_0000};
        vecs[4]  = '{24'h01AB00, 12, 1'b0, 24'h000000, 0, 7'd2, 64'h0000_1234_0000_0000};
        vecs[5]  = '{24'h01CDEF, 24, 1'b1, 24'hA50000, 1, 7'd1, 64'h0000_1234_CDEF_0000};
        vecs[6]  = '{24'h810000, 24, 1'b1, 24'hA5CDEF, 0, 7'd1, 64'h0000_1234_CDEF_0000};
        vecs[7]  = '{24'h00FFFF, 24, 1'b1, 24'hA50000, 1, 7'd0, 64'h0000_1234_CDEF_FFFF};
        vecs[8]  = '{24'h031234, 28, 1'b1, 24'hA50000, 1, 7'd3, 64'h1234_1234_CDEF_FFFF};
        vecs[9]  = '{24'h830000, 24, 1'b1, 24'hA51234, 0, 7'd3, 64'h1234_1234_CDEF_FFFF};
        vecs[10] = '{24'h800000, 24, 1'b1, 24'hA5FFFF, 0, 7'd3, 64'h1234_1234_CDEF_FFFF};

        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(12);
        check("reset reg_q", regq, 64'h0);
        check("reset oe", 64'(oe), 64'd0);
        check("reset miso", 64'(miso), 64'd0);
        check("reset wr_addr", 64'(waddr), 64'd0);
        check("reset no strobe", 64'(strobe_cnt), 64'd0);
`ifdef SPI_SLAVE_WR_IRQ_EN
        check("reset irq", 64'(irq), 64'd0);
`endif

        for (int i = 0; i < 11; i++) begin
            s0 = strobe_cnt;
            run_frame(vecs[i].frame, vecs[i].nbits, vecs[i].chk_miso, vecs[i].exp_miso,
                      $sformatf("v%0d", i));
            check($sformatf("v%0d strobes", i), 64'(strobe_cnt - s0), 64'(vecs[i].exp_strobes));
            check($sformatf("v%0d wr_addr", i), 64'(waddr), 64'(vecs[i].exp_waddr));
            check($sformatf("v%0d reg_q", i), regq, vecs[i].exp_regs);
            check($sformatf("v%0d oe_idle", i), 64'(oe), 64'd0);
        end

`ifdef SPI_SLAVE_WR_IRQ_EN
        run_frame(24'h030007, 24, 1'b1, 24'hA50000, "irq_wr");
        check("irq set", 64'(irq), 64'd1);
        run_frame(24'hFF0000, 24, 1'b1, 24'hA50003, "irq_rd7f");
        check("irq cleared", 64'(irq), 64'd0);
        run_frame(24'h020001, 24, 1'b1, 24'hA50000, "irq_wr2");
        check("irq set again", 64'(irq), 64'd1);
`endif

        // Reset arriving 20 bits into a write frame.
        ss_n = 1'b0;
        clks(8);
        for (int i = 0; i < 20; i++) begin
            mosi = (i < 8) ? (((8'h03) >> (7 - i)) & 1'b1) : 1'b1;
            clks(HALF);
            sclk = 1'b1;
            clks(HALF);
            sclk = 1'b0;
        end
        rst  = 1'b1;
        ss_n = 1'b1;
        clks(2);
        check("midrst reg_q", regq, 64'h0);
        check("midrst oe", 64'(oe), 64'd0);
        check("midrst miso", 64'(miso), 64'd0);
        check("midrst wr_addr", 64'(waddr), 64'd0);
`ifdef SPI_SLAVE_WR_IRQ_EN
        check("midrst irq", 64'(irq), 64'd0);
`endif
        rst = 1'b0;
        clks(10);
        s0 = strobe_cnt;
        run_frame(24'h02BEEF, 24, 1'b1, 24'hA50000, "post_rst_wr");
        check("post_rst strobes", 64'(strobe_cnt - s0), 64'd1);
        check("post_rst reg_q", regq, 64'h0000_BEEF_0000_0000);
        run_frame(24'h820000, 24, 1'b1, 24'hA5BEEF, "post_rst_rd");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
